// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with per-entry saturating-counter BHT, same-cycle lookup, EX-stage update.
// Optional statistics counters are enabled by defining BPU_STATS_EN.
module branch_predict_unit #(
    parameter int ENTRY_NUM = 64,
    parameter int TAG_W     = 8,
    parameter int CNT_W     = 2,
    parameter int STAT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       PCF,
    output logic [31:0]       PredictedPC,
    output logic              PredictedF,
    input  logic              UpdateE,
    input  logic [31:0]       PCE,
    input  logic [31:0]       BrNPC,
    input  logic              BranchE,
    input  logic              PredictedE,
    output logic              MispredE,
    input  logic              StatClr,
    output logic [STAT_W-1:0] BranchCnt,
    output logic [STAT_W-1:0] MispredCnt
);

    localparam int IDX_W = $clog2(ENTRY_NUM);
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W-1)) - 1);
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W-1));
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             r_valid  [ENTRY_NUM];
    logic [TAG_W-1:0] r_tag    [ENTRY_NUM];
    logic [31:0]      r_target [ENTRY_NUM];
    logic [CNT_W-1:0] r_cnt    [ENTRY_NUM];

    logic [IDX_W-1:0] w_idx_f;
    logic [IDX_W-1:0] w_idx_e;
    logic [TAG_W-1:0] w_tag_f;
    logic [TAG_W-1:0] w_tag_e;
    logic             w_hit_f;
    logic             w_hit_e;
    logic             w_unused_bits;

    assign w_idx_f = PCF[IDX_W+1:2];
    assign w_idx_e = PCE[IDX_W+1:2];
    assign w_tag_f = PCF[IDX_W+TAG_W+1:IDX_W+2];
    assign w_tag_e = PCE[IDX_W+TAG_W+1:IDX_W+2];

    // Lookup: reads only registered state, so a same-cycle update is seen next cycle.
    assign w_hit_f     = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
    assign PredictedF  = w_hit_f && r_cnt[w_idx_f][CNT_W-1];
    assign PredictedPC = PredictedF ? r_target[w_idx_f] : (PCF + 32'd4);

    assign w_hit_e  = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);
    assign MispredE = UpdateE && (PredictedE ^ BranchE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                r_valid[i] <= 1'b0;
                r_cnt[i]   <= CNT_WNT;
            end
        end else if (UpdateE) begin
            if (w_hit_e) begin
                if (BranchE) begin
                    if (r_cnt[w_idx_e] != CNT_MAX)
                        r_cnt[w_idx_e] <= r_cnt[w_idx_e] + 1'b1;
                end else begin
                    if (r_cnt[w_idx_e] != '0)
                        r_cnt[w_idx_e] <= r_cnt[w_idx_e] - 1'b1;
                end
            end else if (BranchE) begin
                r_valid[w_idx_e] <= 1'b1;
                r_cnt[w_idx_e]   <= CNT_WT;
            end
        end
    end

    // Tag and target carry no reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (UpdateE && BranchE) begin
            r_target[w_idx_e] <= BrNPC;
            if (!w_hit_e)
                r_tag[w_idx_e] <= w_tag_e;
        end
    end

`ifdef BPU_STATS_EN
    logic [STAT_W-1:0] r_branch_cnt;
    logic [STAT_W-1:0] r_mispred_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (StatClr) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (UpdateE && (r_branch_cnt != {STAT_W{1'b1}}))
                r_branch_cnt <= r_branch_cnt + 1'b1;
            if (MispredE && (r_mispred_cnt != {STAT_W{1'b1}}))
                r_mispred_cnt <= r_mispred_cnt + 1'b1;
        end
    end

    assign BranchCnt     = r_branch_cnt;
    assign MispredCnt    = r_mispred_cnt;
    assign w_unused_bits = ^{PCF, PCE};
`else
    assign BranchCnt     = '0;
    assign MispredCnt    = '0;
    assign w_unused_bits = ^{PCF, PCE, StatClr};
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit (64 entries, 8-bit tag, 2-bit counters).
// Statistics expectations follow BPU_STATS_EN; a narrow STAT_W exposes counter saturation.
module tb_branch_predict_unit;

    localparam int STAT_W = 4;

    logic              clk;
    logic              rst_n;
    logic [31:0]       PCF;
    logic [31:0]       PredictedPC;
    logic              PredictedF;
    logic              UpdateE;
    logic [31:0]       PCE;
    logic [31:0]       BrNPC;
    logic              BranchE;
    logic              PredictedE;
    logic              MispredE;
    logic              StatClr;
    logic [STAT_W-1:0] BranchCnt;
    logic [STAT_W-1:0] MispredCnt;

    int errors = 0;
    int checks = 0;

    branch_predict_unit #(
        .ENTRY_NUM(64), .TAG_W(8), .CNT_W(2), .STAT_W(STAT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .PCF(PCF), .PredictedPC(PredictedPC),
        .PredictedF(PredictedF), .UpdateE(UpdateE), .PCE(PCE), .BrNPC(BrNPC),
        .BranchE(BranchE), .PredictedE(PredictedE), .MispredE(MispredE),
        .StatClr(StatClr), .BranchCnt(BranchCnt), .MispredCnt(MispredCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc,
                          input logic pf, input logic [31:0] ppc);
        PCF = pc;
        #1;
        check({tag, "_pf"}, {31'd0, PredictedF}, {31'd0, pf});
        check({tag, "_pc"}, PredictedPC, ppc);
    endtask

    // Drive one update across a rising edge, then drop UpdateE.
    task automatic update(input logic [31:0] pc, input logic [31:0] tgt,
                          input logic br, input logic pred);
        UpdateE = 1'b1; PCE = pc; BrNPC = tgt; BranchE = br; PredictedE = pred;
        @(posedge clk); #1;
        UpdateE = 1'b0;
    endtask

    function automatic logic [31:0] stat_exp(input int v);
`ifdef BPU_STATS_EN
        return 32'(v);
`else
        return 32'(v * 0);
`endif
    endfunction

    initial begin
        rst_n = 1'b0; PCF = 32'h10; UpdateE = 1'b0; PCE = '0; BrNPC = '0;
        BranchE = 1'b0; PredictedE = 1'b0; StatClr = 1'b0;
        #3;
        lookup("rst_low", 32'h10, 1'b0, 32'h14);
        check("rst_bcnt", 32'(BranchCnt), 32'd0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        lookup("rst_high", 32'h10, 1'b0, 32'h14);

        // Allocation: same-cycle lookup still sees the old (empty) entry.
        UpdateE = 1'b1; PCE = 32'h10; BrNPC = 32'h80; BranchE = 1'b1; PredictedE = 1'b0;
        #1;
        check("alloc_same_cycle_pf", {31'd0, PredictedF}, 32'd0);
        check("alloc_mispred", {31'd0, MispredE}, 32'd1);
        @(posedge clk); #1;
        UpdateE = 1'b0;
        #1;
        check("mispred_idle", {31'd0, MispredE}, 32'd0);
        lookup("alloc", 32'h10, 1'b1, 32'h80);

        update(32'h10, 32'h80, 1'b0, 1'b1);
        lookup("cnt01", 32'h10, 1'b0, 32'h14);

        update(32'h10, 32'h80, 1'b1, 1'b0);
        lookup("cnt10", 32'h10, 1'b1, 32'h80);
        update(32'h10, 32'h80, 1'b1, 1'b1);
        update(32'h10, 32'h80, 1'b1, 1'b1);
        update(32'h10, 32'h80, 1'b1, 1'b1);
        update(32'h10, 32'h80, 1'b0, 1'b1);
        lookup("sat_then_dec", 32'h10, 1'b1, 32'h80);

        // 0x110 aliases idx 4 with a different tag: replaces the entry.
        update(32'h110, 32'h200, 1'b1, 1'b0);
        lookup("alias_old", 32'h10, 1'b0, 32'h14);
        lookup("alias_new", 32'h110, 1'b1, 32'h200);

        update(32'h10, 32'h300, 1'b0, 1'b0);
        lookup("nt_miss_noalloc_old", 32'h10, 1'b0, 32'h14);
        lookup("nt_miss_noalloc_new", 32'h110, 1'b1, 32'h200);

        // Taken hit refreshes the target.
        update(32'h110, 32'h240, 1'b1, 1'b1);
        lookup("target_refresh", 32'h110, 1'b1, 32'h240);

        StatClr = 1'b1; @(posedge clk); #1; StatClr = 1'b0;
        check("clr_bcnt", 32'(BranchCnt), 32'd0);
        check("clr_mcnt", 32'(MispredCnt), 32'd0);
        update(32'h10, 32'h80, 1'b1, 1'b1);
        UpdateE = 1'b1; PCE = 32'h10; BrNPC = 32'h80; BranchE = 1'b1; PredictedE = 1'b0;
        #1;
        check("mispred_pulse", {31'd0, MispredE}, 32'd1);
        @(posedge clk); #1; UpdateE = 1'b0;
        update(32'h10, 32'h80, 1'b1, 1'b1);
        check("stat_bcnt", 32'(BranchCnt), stat_exp(3));
        check("stat_mcnt", 32'(MispredCnt), stat_exp(1));

        StatClr = 1'b1;
        update(32'h10, 32'h80, 1'b1, 1'b0);
        StatClr = 1'b0;
        check("clr_inc_bcnt", 32'(BranchCnt), 32'd0);
        check("clr_inc_mcnt", 32'(MispredCnt), 32'd0);

        for (int i = 0; i < 20; i++) update(32'h10, 32'h80, 1'b0, 1'b1);
        check("stat_sat_bcnt", 32'(BranchCnt), stat_exp(15));
        check("stat_sat_mcnt", 32'(MispredCnt), stat_exp(15));

        // Reset asserted in the middle of an update cycle.
        UpdateE = 1'b1; PCE = 32'h110; BrNPC = 32'h400; BranchE = 1'b1; PredictedE = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        lookup("midupd_rst", 32'h110, 1'b0, 32'h114);
        check("midupd_rst_bcnt", 32'(BranchCnt), 32'd0);
        @(posedge clk); #1;
        UpdateE = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        lookup("post_rst", 32'h110, 1'b0, 32'h114);

        // After reset the counter starts weakly not-taken; allocation makes it weakly taken.
        update(32'h110, 32'h200, 1'b1, 1'b0);
        update(32'h110, 32'h200, 1'b0, 1'b1);
        lookup("post_rst_dec", 32'h110, 1'b0, 32'h114);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
